// File: rtl/sram_counter_if.sv
// Tester-side control and status signals of the emulated counter/SRAM target.
// The data nibbles are bidirectional pins and stay as plain inout ports on the responder.
interface sram_counter_if #(
    parameter int CNT_W = 12
);
    logic             COUNTER_CLK;
    logic             COUNTER_RST;
    logic             WE_BAR;
    logic [CNT_W-1:0] COUNT;
    logic             WR_STROBE;
    logic [7:0]       WRITE_CNT;
    logic             ADDR_VIOL;

    modport master (
        output COUNTER_CLK, COUNTER_RST, WE_BAR,
        input  COUNT, WR_STROBE, WRITE_CNT, ADDR_VIOL
    );

    modport slave (
        input  COUNTER_CLK, COUNTER_RST, WE_BAR,
        output COUNT, WR_STROBE, WRITE_CNT, ADDR_VIOL
    );
endinterface

// File: rtl/sram_counter_responder.sv
// Emulates the MC14040B ripple counter and two 4-bit SRAMs behind the tester's pins,
// and flags any counter movement while a write is in progress.
module sram_counter_responder #(
    parameter int CNT_W       = 12,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          CLK,
    input  logic          RST,
    sram_counter_if.slave bus,
    inout  wire [3:0]     CHIP1_DATA,
    inout  wire [3:0]     CHIP2_DATA
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int SW    = 11;
    // {counter_clk, counter_rst, we_bar, chip1, chip2}; control lines idle high
    localparam logic [SW-1:0] SYNC_IDLE = 11'b111_0000_0000;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WR   = 1'b1;

    logic [SW-1:0]     sync_reg [SYNC_STAGES];
    logic [SW-1:0]     raw_in;
    logic              cc_s;
    logic              crst_s;
    logic              we_s;
    logic [7:0]        data_s;
    logic              cc_q_reg;

    logic [CNT_W-1:0]  count_reg;
    logic [0:0]        state_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [7:0]        wr_data_reg;
    logic              strobe_reg;
    logic [7:0]        write_cnt_reg;
    logic              viol_reg;
    logic [7:0]        rd_q_reg;
    logic [7:0]        mem_word [DEPTH];

    logic              cnt_fall;
    logic              commit;
    logic              drive;

    assign raw_in = {bus.COUNTER_CLK, bus.COUNTER_RST, bus.WE_BAR, CHIP1_DATA, CHIP2_DATA};

    // Data travels through the same stages as WE_BAR so it stays aligned with we_s
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= SYNC_IDLE;
            cc_q_reg <= 1'b1;
        end else begin
            sync_reg[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
            cc_q_reg <= cc_s;
        end
    end

    assign cc_s     = sync_reg[SYNC_STAGES-1][10];
    assign crst_s   = sync_reg[SYNC_STAGES-1][9];
    assign we_s     = sync_reg[SYNC_STAGES-1][8];
    assign data_s   = sync_reg[SYNC_STAGES-1][7:0];

    assign cnt_fall = cc_q_reg & ~cc_s;
    assign commit   = (state_reg == ST_WR) & we_s;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_reg     <= '0;
            state_reg     <= ST_IDLE;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            strobe_reg    <= 1'b0;
            write_cnt_reg <= '0;
            viol_reg      <= 1'b0;
            rd_q_reg      <= '0;
        end else begin
            if (crst_s)
                count_reg <= '0;
            else if (cnt_fall)
                count_reg <= count_reg + 1'b1;

            strobe_reg <= commit;
            if (commit && write_cnt_reg != 8'hFF)
                write_cnt_reg <= write_cnt_reg + 8'd1;

            // The 0->1 commit cycle has we_s high, so it is excluded here
            if (state_reg == ST_WR && !we_s && (crst_s || cnt_fall))
                viol_reg <= 1'b1;

            if (!we_s)
                wr_data_reg <= data_s;

            case (state_reg)
                ST_IDLE: if (!we_s) begin
                    state_reg   <= ST_WR;
                    wr_addr_reg <= count_reg[ADDR_W-1:0];
                end
                default: if (we_s) state_reg <= ST_IDLE;
            endcase

            rd_q_reg <= mem_word[count_reg[ADDR_W-1:0]];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            logic [7:0] word_reg;
            always_ff @(posedge CLK) begin
                if (RST)
                    word_reg <= '0;
                else if (commit && wr_addr_reg == ADDR_W'(gi))
                    word_reg <= wr_data_reg;
            end
            assign mem_word[gi] = word_reg;
        end
    endgenerate

    // Raw WE_BAR releases the bus the moment the tester starts driving
    assign drive      = ~RST & bus.WE_BAR & we_s;
    assign CHIP1_DATA = drive ? rd_q_reg[7:4] : 4'bz;
    assign CHIP2_DATA = drive ? rd_q_reg[3:0] : 4'bz;

    assign bus.COUNT     = count_reg;
    assign bus.WR_STROBE = strobe_reg;
    assign bus.WRITE_CNT = write_cnt_reg;
    assign bus.ADDR_VIOL = viol_reg;
endmodule
